// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith ops plus
// iterative bit-serial shifts and a radix-2 shift-add multiplier.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned CW = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b1000;
    localparam logic [3:0] OP_LSR  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic             accept_c;
    logic             load_c;
    logic [WIDTH-1:0] shift_c;
    logic [WIDTH-1:0] add_c;

    assign accept_c = in_valid && (state_q == S_IDLE);
    assign shift_c  = dir_q ? (work_q >> 1) : (work_q << 1);
    assign add_c    = acc_q + (mplier_q[0] ? work_q : '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (alu_ctrl == OP_LSL || alu_ctrl == OP_LSR) begin
                        state_d = (b[SHW-1:0] == '0) ? S_DONE : S_SHIFT;
                    end else if (alu_ctrl == OP_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: if (cnt_q == CW'(1)) state_d = S_DONE;
            S_MUL:   if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (state_q == S_IDLE) in_ready  = 1'b1;
        if (state_q == S_DONE) out_valid = 1'b1;
    end

    // Datapath next values: operand latch, iteration step, result load
    always_comb begin
        work_d    = work_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        load_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    illegal_d = 1'b0;
                    unique case (alu_ctrl)
                        OP_AND:  begin result_d = a & b; load_c = 1'b1; end
                        OP_ORR:  begin result_d = a | b; load_c = 1'b1; end
                        OP_ADD:  begin result_d = a + b; load_c = 1'b1; end
                        OP_SUB:  begin result_d = a - b; load_c = 1'b1; end
                        OP_PASS: begin result_d = b;     load_c = 1'b1; end
                        OP_LSL, OP_LSR: begin
                            work_d = a;
                            dir_d  = (alu_ctrl == OP_LSR);
                            cnt_d  = CW'(b[SHW-1:0]);
                            if (b[SHW-1:0] == '0) begin
                                result_d = a;
                                load_c   = 1'b1;
                            end
                        end
                        OP_MUL: begin
                            work_d   = a;
                            mplier_d = b;
                            acc_d    = '0;
                            cnt_d    = CW'(WIDTH);
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                            load_c    = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                work_d = shift_c;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = shift_c;
                    load_c   = 1'b1;
                end
            end
            S_MUL: begin
                acc_d    = add_c;
                work_d   = work_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = add_c;
                    load_c   = 1'b1;
                end
            end
            default: ;
        endcase
        if (load_c) zero_d = (result_d == '0);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q    <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            work_q    <= work_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(64), .SHW(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag and accept-to-out_valid latency
    function automatic void model(input logic [3:0] c, input logic [63:0] x,
                                  input logic [63:0] y, output logic [63:0] r,
                                  output logic ill, output int lat);
        logic [5:0] sh;
        sh  = y[5:0];
        ill = 1'b0;
        lat = 1;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = y;
            4'b1000: begin r = x << sh; lat = (sh == 0) ? 1 : int'(sh) + 1; end
            4'b1001: begin r = x >> sh; lat = (sh == 0) ? 1 : int'(sh) + 1; end
            4'b1010: begin r = x * y;   lat = 65; end
            default: begin r = 64'd0;   ill = 1'b1; end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] x,
                          input logic [63:0] y, input int stall);
        logic [63:0] exp_r;
        logic        exp_ill;
        int          exp_lat;
        int          k;
        bit          found;
        model(c, x, y, exp_r, exp_ill, exp_lat);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        k     = 0;
        found = 1'b0;
        while (k < 200 && !found) begin
            @(negedge clk);
            k++;
            if (out_valid) found = 1'b1;
        end
        check({tag, ".latency"}, 64'(k), 64'(exp_lat));
        check({tag, ".result"}, result, exp_r);
        check({tag, ".zero"}, 64'(zero), 64'(exp_r == 64'd0));
        check({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
        check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = (i == 3);
            alu_ctrl = 4'b0010;
            check({tag, ".stall_result"}, result, exp_r);
            check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".stall_in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1111};

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        a         = 64'd0;
        b         = 64'd0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result", result, 64'd0);
        check("rst.zero", 64'(zero), 64'd0);
        check("rst.illegal", 64'(illegal), 64'd0);
        reset = 1'b0;

        run_op("add", 4'b0010, 64'd5, 64'd7, 0);
        run_op("sub_eq", 4'b0110, 64'd3, 64'd3, 0);
        run_op("sub_neg", 4'b0110, 64'd0, 64'd1, 0);
        run_op("passb0", 4'b0111, 64'd5, 64'd0, 0);
        run_op("lsl4", 4'b1000, 64'd1, 64'd4, 0);
        run_op("lsr63", 4'b1001, 64'h8000_0000_0000_0000, 64'd63, 0);
        run_op("lsl0", 4'b1000, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
        run_op("mul", 4'b1010, 64'h1_0000_0001, 64'd3, 0);
        run_op("mul_trunc", 4'b1010, 64'h8000_0000_0000_0000, 64'd2, 0);
        run_op("and_stall", 4'b0000, 64'hF0, 64'h3C, 10);
        repeat (3) begin
            @(negedge clk);
            check("stall_pulse_dropped", 64'(out_valid), 64'd0);
        end
        run_op("illegal", 4'b1111, 64'hDEAD, 64'hBEEF, 0);

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = 4'b1010;
        a        = 64'd12345;
        b        = 64'd678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mulrst.out_valid", 64'(out_valid), 64'd0);
        check("mulrst.in_ready", 64'(in_ready), 64'd1);
        check("mulrst.result", result, 64'd0);
        check("mulrst.illegal", 64'(illegal), 64'd0);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mulrst.no_output", 64'(seen), 64'd0);
        run_op("orr_after_rst", 4'b0001, 64'h1, 64'h2, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  c;
            logic [63:0] x;
            logic [63:0] y;
            c = ops[$urandom_range(0, 9)];
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (n % 7 == 0) y = 64'd0;
            if (n % 11 == 0) x = y;
            run_op($sformatf("rand%0d", n), c, x, y, int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
